host_frame_sequencer: RTL and testbench

//  Mailbox-driven sequencer between the PCI host and the user compute core.
//  - Host starts a job by writing START_CMD to the flag word.
//  - Block acks, selects the next of NUM_FRAMES frame buffers (round-robin) and serves user read/write requests as

---
 rtl/host_frame_sequencer_if.sv | 47 ++++
 rtl/host_frame_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_host_frame_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_frame_sequencer_if.sv
// Bundle of the host mailbox, user request and memory bus signals of the
// frame sequencer. The sequencer owns the memory bus, so it takes the master
// side; the host/user/memory environment takes the slave side.
interface host_frame_sequencer_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32,
    parameter int FIDX_W = 1
);
    // Host mailbox writes
    logic              pci_wr_en;
    logic [ADDR_W-1:0] pci_req_addr;
    logic [DATA_W-1:0] pci_input_data;
    // User compute core requests
    logic              usr_req;
    logic              usr_rd_wr;
    logic [ADDR_W-1:0] usr_addr;
    logic [DATA_W-1:0] usr_wdata;
    logic              usr_set_done;
    logic              usr_ready;
    logic              usr_rvalid;
    logic [DATA_W-1:0] usr_rdata;
    logic [FIDX_W-1:0] busy_frame;
    // Memory side
    logic              mem_rd_req;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd_ready;
    logic [DATA_W-1:0] mem_rd_data;
    logic              flag_we;

    modport master (
        input  pci_wr_en, pci_req_addr, pci_input_data,
        input  usr_req, usr_rd_wr, usr_addr, usr_wdata, usr_set_done,
        input  mem_rd_ready, mem_rd_data,
        output usr_ready, usr_rvalid, usr_rdata, busy_frame,
        output mem_rd_req, mem_wr_en, mem_addr, mem_wdata, flag_we
    );

    modport slave (
        output pci_wr_en, pci_req_addr, pci_input_data,
        output usr_req, usr_rd_wr, usr_addr, usr_wdata, usr_set_done,
        output mem_rd_ready, mem_rd_data,
        input  usr_ready, usr_rvalid, usr_rdata, busy_frame,
        input  mem_rd_req, mem_wr_en, mem_addr, mem_wdata, flag_we
    );
endinterface

// File: rtl/host_frame_sequencer.sv
// Mailbox-driven job sequencer between the PCI host and the user compute core.
// A host START write to the flag word kicks off a job on the next frame buffer
// (round-robin); the user then reads/writes frame-relative offsets until it
// signals done, and the outcome (DONE/ERR with frame index) is posted back to
// the flag word. All outputs are registered.
module host_frame_sequencer #(
    parameter int               ADDR_W      = 21,
    parameter int               DATA_W      = 32,
    parameter int               NUM_FRAMES  = 2,
    parameter int               FRAME_WORDS = 'h10000,
    parameter logic [ADDR_W-1:0] FLAG_ADDR  = 21'h07FFFE,
    parameter logic [DATA_W-1:0] START_CMD  = 32'h0001_0000,
    parameter logic [DATA_W-1:0] ABORT_CMD  = 32'h0002_0000,
    parameter logic [7:0]       ACK_CODE    = 8'd2,
    parameter logic [7:0]       DONE_CODE   = 8'd4,
    parameter logic [7:0]       ERR_CODE    = 8'd8,
    parameter bit               SWAP_BYTES  = 1'b1,
    parameter int               TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    host_frame_sequencer_if.master bus
);
    localparam int FIDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int NB     = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [FIDX_W-1:0] LAST_FRAME    = FIDX_W'(NUM_FRAMES - 1);
    localparam logic [ADDR_W-1:0] FRAME_WORDS_A = ADDR_W'(FRAME_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ACK, ST_RUN, ST_RD_WAIT, ST_DONE, ST_ERR
    } state_t;

    state_t              state_reg, state_next;
    logic [FIDX_W-1:0]   busy_frame_reg;
    logic [CNT_W-1:0]    cnt_reg;

    logic                usr_ready_reg,  usr_ready_next;
    logic                usr_rvalid_reg, usr_rvalid_next;
    logic [DATA_W-1:0]   usr_rdata_reg,  usr_rdata_next;
    logic                mem_rd_req_reg, mem_rd_req_next;
    logic                mem_wr_en_reg,  mem_wr_en_next;
    logic [ADDR_W-1:0]   mem_addr_reg,   mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_reg,  mem_wdata_next;
    logic                flag_we_reg,    flag_we_next;

    logic                host_flag_wr;
    logic                start_hit;
    logic                abort_hit;
    logic [ADDR_W-1:0]   access_addr;
    logic [DATA_W-1:0]   wdata_mem;
    logic [DATA_W-1:0]   rdata_usr;
    logic [DATA_W-1:0]   flag_status;

    assign host_flag_wr = bus.pci_wr_en && (bus.pci_req_addr == FLAG_ADDR);
    assign start_hit    = host_flag_wr && (bus.pci_input_data == START_CMD);
    assign abort_hit    = host_flag_wr && (bus.pci_input_data == ABORT_CMD);

    // Frame-relative offset rebased onto the active frame; wraps at ADDR_W bits
    assign access_addr = (ADDR_W'(busy_frame_reg) * FRAME_WORDS_A) + bus.usr_addr;

    // Byte lane mapping between user and memory byte order (same in both directions)
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            if (SWAP_BYTES) begin : g_rev
                assign wdata_mem[gi*8 +: 8] = bus.usr_wdata[(NB-1-gi)*8 +: 8];
                assign rdata_usr[gi*8 +: 8] = bus.mem_rd_data[(NB-1-gi)*8 +: 8];
            end else begin : g_keep
                assign wdata_mem[gi*8 +: 8] = bus.usr_wdata[gi*8 +: 8];
                assign rdata_usr[gi*8 +: 8] = bus.mem_rd_data[gi*8 +: 8];
            end
        end
    endgenerate

    // Completion word: frame index in bits [15:8], status code OR-ed into [7:0]
    always_comb begin
        flag_status = '0;
        flag_status[8 +: FIDX_W] = busy_frame_reg;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state decision; abort outranks done, done outranks a user request
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (start_hit) state_next = ST_ACK;
            ST_ACK:     state_next = ST_RUN;
            ST_RUN: begin
                if (abort_hit)                               state_next = ST_ERR;
                else if (bus.usr_set_done)                   state_next = ST_DONE;
                else if (bus.usr_req && !bus.usr_rd_wr)      state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (abort_hit)                state_next = ST_ERR;
                else if (bus.mem_rd_ready)    state_next = ST_RUN;
                else if (cnt_reg == CNT_LAST) state_next = ST_ERR;
            end
            ST_DONE:    state_next = ST_IDLE;
            ST_ERR:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Output decision for the next cycle, derived from current state and inputs
    always_comb begin
        usr_ready_next  = (state_next == ST_RUN);
        usr_rvalid_next = 1'b0;
        usr_rdata_next  = usr_rdata_reg;
        mem_rd_req_next = 1'b0;
        mem_wr_en_next  = 1'b0;
        mem_addr_next   = '0;
        mem_wdata_next  = '0;
        flag_we_next    = 1'b0;
        case (state_reg)
            ST_ACK: begin
                mem_wr_en_next = 1'b1;
                flag_we_next   = 1'b1;
                mem_addr_next  = FLAG_ADDR;
                mem_wdata_next = DATA_W'(ACK_CODE);
            end
            ST_RUN: begin
                if (!abort_hit && !bus.usr_set_done && bus.usr_req) begin
                    mem_addr_next = access_addr;
                    if (bus.usr_rd_wr) begin
                        mem_wr_en_next = 1'b1;
                        mem_wdata_next = wdata_mem;
                    end else begin
                        mem_rd_req_next = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (!abort_hit && bus.mem_rd_ready) begin
                    usr_rvalid_next = 1'b1;
                    usr_rdata_next  = rdata_usr;
                end
            end
            ST_DONE: begin
                mem_wr_en_next = 1'b1;
                flag_we_next   = 1'b1;
                mem_addr_next  = FLAG_ADDR;
                mem_wdata_next = flag_status | DATA_W'(DONE_CODE);
            end
            ST_ERR: begin
                mem_wr_en_next = 1'b1;
                flag_we_next   = 1'b1;
                mem_addr_next  = FLAG_ADDR;
                mem_wdata_next = flag_status | DATA_W'(ERR_CODE);
            end
            default: ;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            usr_ready_reg  <= 1'b0;
            usr_rvalid_reg <= 1'b0;
            usr_rdata_reg  <= '0;
            mem_rd_req_reg <= 1'b0;
            mem_wr_en_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            flag_we_reg    <= 1'b0;
        end else begin
            usr_ready_reg  <= usr_ready_next;
            usr_rvalid_reg <= usr_rvalid_next;
            usr_rdata_reg  <= usr_rdata_next;
            mem_rd_req_reg <= mem_rd_req_next;
            mem_wr_en_reg  <= mem_wr_en_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            flag_we_reg    <= flag_we_next;
        end
    end

    // Round-robin frame selection on each accepted start; reset leaves the
    // last frame selected so the first job lands on frame 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_frame_reg <= LAST_FRAME;
        end else if (state_reg == ST_IDLE && start_hit) begin
            busy_frame_reg <= (busy_frame_reg == LAST_FRAME) ? '0 : busy_frame_reg + FIDX_W'(1);
        end
    end

    // Read-wait cycle counter, cleared whenever not waiting on memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     cnt_reg <= '0;
        else if (state_reg == ST_RD_WAIT) cnt_reg <= cnt_reg + CNT_W'(1);
        else                            cnt_reg <= '0;
    end

    assign bus.usr_ready  = usr_ready_reg;
    assign bus.usr_rvalid = usr_rvalid_reg;
    assign bus.usr_rdata  = usr_rdata_reg;
    assign bus.busy_frame = busy_frame_reg;
    assign bus.mem_rd_req = mem_rd_req_reg;
    assign bus.mem_wr_en  = mem_wr_en_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.flag_we    = flag_we_reg;
endmodule

// File: tb/tb_host_frame_sequencer.sv
// Randomized bench for host_frame_sequencer: a job-level reference model
// predicts every memory-side event (data write, flag write, read request,
// user read return) and a monitor matches what the DUT actually emits.
module tb_host_frame_sequencer;
    localparam int AW  = 21;
    localparam int DW  = 32;
    localparam int NF  = 2;
    localparam int FW  = 'h10000;
    localparam int TMO = 1024;
    localparam logic [AW-1:0] FLAG  = 21'h07FFFE;
    localparam logic [DW-1:0] START = 32'h0001_0000;
    localparam logic [DW-1:0] ABORT = 32'h0002_0000;
    localparam int K_WR = 0, K_FLAG = 1, K_RD = 2, K_RV = 3;

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    host_frame_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .FIDX_W(1)) bus();

    host_frame_sequencer dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  job_cnt = 0;   // jobs started since the last reset

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] swap(input logic [DW-1:0] d);
        return {<<8{d}};
    endfunction

    // Frame used by the current job: jobs rotate through frames starting at 0
    function automatic int cur_frame();
        return (job_cnt - 1) % NF;
    endfunction

    function automatic logic [DW-1:0] flag_word(input int code);
        return DW'(cur_frame() * 256 + code);
    endfunction

    function automatic logic [AW-1:0] frame_addr(input int off);
        return AW'(cur_frame() * FW + off);
    endfunction

    task automatic push_ev(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_val("unexpected_event_kind", 64'(kind), 64'd99);
            return;
        end
        e = exp_q.pop_front();
        check_val("ev_kind", 64'(kind), 64'(e.kind));
        if (e.kind != K_RV) check_val("ev_addr", addr, e.addr);
        if (e.kind != K_RD) check_val("ev_data", data, e.data);
    endtask

    // Monitor of DUT-emitted events, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_wr_en)  match_ev(bus.flag_we ? K_FLAG : K_WR, bus.mem_addr, bus.mem_wdata);
            if (bus.mem_rd_req) match_ev(K_RD, bus.mem_addr, '0);
            if (bus.usr_rvalid) match_ev(K_RV, '0, bus.usr_rdata);
            if (bus.flag_we && !bus.mem_wr_en) check_val("flag_we_stray", bus.flag_we, 1'b0);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.pci_wr_en = 1'b1; bus.pci_req_addr = a; bus.pci_input_data = d;
        @(negedge clk);
        bus.pci_wr_en = 1'b0; bus.pci_req_addr = '0; bus.pci_input_data = '0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.usr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, bus.usr_ready, 1'b1);
    endtask

    task automatic start_job();
        job_cnt++;
        push_ev(K_FLAG, FLAG, 32'h2);
        host_write(FLAG, START);
        wait_ready("start_ready");
        check_val("busy_frame", bus.busy_frame, 64'(cur_frame()));
        $display("start job %0d frame %0d", job_cnt, cur_frame());
    endtask

    task automatic user_write(input int off, input logic [DW-1:0] d);
        wait_ready("wr_ready");
        push_ev(K_WR, frame_addr(off), swap(d));
        bus.usr_req = 1'b1; bus.usr_rd_wr = 1'b1; bus.usr_addr = AW'(off); bus.usr_wdata = d;
        @(negedge clk);
        bus.usr_req = 1'b0; bus.usr_rd_wr = 1'b0;
        $display("write frame %0d off 0x%0h data 0x%h", cur_frame(), off, d);
    endtask

    task automatic accept_read(input int off);
        wait_ready("rd_ready");
        push_ev(K_RD, frame_addr(off), '0);
        bus.usr_req = 1'b1; bus.usr_rd_wr = 1'b0; bus.usr_addr = AW'(off);
        @(negedge clk);
        bus.usr_req = 1'b0;
    endtask

    task automatic user_read(input int off, input logic [DW-1:0] d, input int delay);
        accept_read(off);
        for (int i = 0; i < delay; i++) begin
            check_val("rd_wait_ready_low", bus.usr_ready, 1'b0);
            @(negedge clk);
        end
        push_ev(K_RV, '0, swap(d));
        check_val("rd_wait_ready_low", bus.usr_ready, 1'b0);
        bus.mem_rd_ready = 1'b1; bus.mem_rd_data = d;
        @(negedge clk);
        bus.mem_rd_ready = 1'b0;
        $display("read frame %0d off 0x%0h mem 0x%h delay %0d", cur_frame(), off, d, delay);
    endtask

    task automatic finish_done(input bit with_req);
        wait_ready("done_ready");
        push_ev(K_FLAG, FLAG, flag_word(4));
        bus.usr_set_done = 1'b1;
        if (with_req) begin
            bus.usr_req = 1'b1; bus.usr_rd_wr = 1'($urandom);
            bus.usr_addr = AW'($urandom_range(0, 'hFFFF)); bus.usr_wdata = $urandom;
        end
        @(negedge clk);
        bus.usr_set_done = 1'b0; bus.usr_req = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_ready_low", bus.usr_ready, 1'b0);
        $display("done job %0d frame %0d req %0d", job_cnt, cur_frame(), with_req);
    endtask

    task automatic abort_job();
        wait_ready("abort_ready");
        push_ev(K_FLAG, FLAG, flag_word(8));
        host_write(FLAG, ABORT);
        repeat (2) @(negedge clk);
        check_val("abort_ready_low", bus.usr_ready, 1'b0);
        $display("abort job %0d frame %0d", job_cnt, cur_frame());
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        check_val(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        check_val("rst_usr_ready",  bus.usr_ready,  1'b0);
        check_val("rst_usr_rvalid", bus.usr_rvalid, 1'b0);
        check_val("rst_usr_rdata",  bus.usr_rdata,  '0);
        check_val("rst_mem_rd_req", bus.mem_rd_req, 1'b0);
        check_val("rst_mem_wr_en",  bus.mem_wr_en,  1'b0);
        check_val("rst_mem_addr",   bus.mem_addr,   '0);
        check_val("rst_mem_wdata",  bus.mem_wdata,  '0);
        check_val("rst_flag_we",    bus.flag_we,    1'b0);
        check_val("rst_busy_frame", bus.busy_frame, 64'(NF - 1));
    endtask

    int r, nops, ending;
    logic [AW-1:0] noise_addr;

    initial begin
        bus.pci_wr_en = 1'b0; bus.pci_req_addr = '0; bus.pci_input_data = '0;
        bus.usr_req = 1'b0; bus.usr_rd_wr = 1'b0; bus.usr_addr = '0; bus.usr_wdata = '0;
        bus.usr_set_done = 1'b0; bus.mem_rd_ready = 1'b0; bus.mem_rd_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Known-value jobs
        start_job();
        user_write(5, 32'h1122_3344);
        finish_done(1'b0);
        drain("job1_drain");
        start_job();
        user_read(3, 32'hAABB_CCDD, 4);
        finish_done(1'b1);
        drain("job2_drain");

        // Start hit while running is ignored; abort ends with ERR
        start_job();
        host_write(FLAG, START);
        @(negedge clk);
        check_val("start_in_run_ready", bus.usr_ready, 1'b1);
        check_val("start_in_run_frame", bus.busy_frame, 64'(cur_frame()));
        user_write(7, 32'hCAFE_F00D);
        abort_job();
        drain("abort_drain");

        // Read timeout, then a late memory response that must be discarded
        start_job();
        accept_read('h42);
        push_ev(K_FLAG, FLAG, flag_word(8));
        for (int i = 0; i < TMO + 8; i++) begin
            if (i == TMO - 10) check_val("tmo_not_early", 64'(exp_q.size()), 64'd1);
            if (i == TMO / 2)  check_val("tmo_ready_low", bus.usr_ready, 1'b0);
            if (i == TMO + 4)  check_val("tmo_posted", 64'(exp_q.size()), 64'd0);
            @(negedge clk);
        end
        bus.mem_rd_ready = 1'b1; bus.mem_rd_data = $urandom;
        @(negedge clk);
        bus.mem_rd_ready = 1'b0;
        check_val("late_rvalid", bus.usr_rvalid, 1'b0);
        $display("timeout job %0d frame %0d", job_cnt, cur_frame());
        drain("tmo_drain");

        // Randomized jobs
        for (int j = 0; j < 25; j++) begin
            start_job();
            nops = $urandom_range(1, 5);
            for (int k = 0; k < nops; k++) begin
                r = $urandom_range(0, 9);
                if (r < 4) begin
                    user_write($urandom_range(0, 'hFFFF), $urandom);
                end else if (r < 8) begin
                    user_read($urandom_range(0, 'hFFFF), $urandom, $urandom_range(0, 6));
                end else if (r == 8) begin
                    noise_addr = AW'($urandom_range(0, 'h7FFFD));
                    host_write(noise_addr, START);
                    $display("host write ignored addr 0x%0h", noise_addr);
                end else begin
                    host_write(FLAG, START);
                    $display("start hit ignored while running");
                end
            end
            ending = $urandom_range(0, 3);
            if (ending == 0)      abort_job();
            else if (ending == 1) finish_done(1'b1);
            else                  finish_done(1'b0);
            drain("rand_drain");
        end

        // Abort while waiting on a read
        start_job();
        accept_read('h10);
        repeat (3) @(negedge clk);
        push_ev(K_FLAG, FLAG, flag_word(8));
        host_write(FLAG, ABORT);
        $display("abort in read wait job %0d", job_cnt);
        drain("rdabort_drain");

        // Reset in the middle of a read wait
        start_job();
        accept_read('h20);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        job_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset during read wait");
        start_job();
        check_val("post_reset_frame", bus.busy_frame, 64'd0);
        finish_done(1'b0);
        drain("post_reset_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
